// File: rtl/mux_sel_pipe.sv
// NUM_IN:1 operand select with a registered, elastic (2-entry skid) output stage.
// Out-of-range selects produce a zero operand, set Out_Err and bump a saturating counter.
module mux_sel_pipe #(
    parameter int WIDTH     = 4,
    parameter int NUM_IN    = 4,
    parameter int ERR_CNT_W = 8,
    localparam int SEL_W    = $clog2(NUM_IN)
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    Flush,
    input  logic [NUM_IN*WIDTH-1:0] In_Data,
    input  logic [SEL_W-1:0]        In_Sel,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    output logic [WIDTH-1:0]        Out_Data,
    output logic [SEL_W-1:0]        Out_Sel,
    output logic                    Out_Err,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic [ERR_CNT_W-1:0]    Err_Count
);

    logic [WIDTH-1:0]     chan [NUM_IN];
    logic [WIDTH-1:0]     entry_data;
    logic                 entry_err;
    logic                 accept;
    logic                 fire;

    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic [SEL_W-1:0]     out_sel_q, out_sel_d;
    logic                 out_err_q, out_err_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     skid_data_q, skid_data_d;
    logic [SEL_W-1:0]     skid_sel_q, skid_sel_d;
    logic                 skid_err_q, skid_err_d;
    logic                 skid_full_q, skid_full_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
        assign chan[gi] = In_Data[gi*WIDTH +: WIDTH];
    end

    always_comb begin
        entry_err  = (int'(In_Sel) >= NUM_IN);
        entry_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(In_Sel) == i) begin
                entry_data = chan[i];
            end
        end
    end

    assign accept = In_Valid & ~skid_full_q;
    assign fire   = out_valid_q & Out_Ready;

    // State is {out_valid, skid_full}: 00 empty, 10 one entry, 11 two entries.
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        skid_err_d  = skid_err_q;
        skid_full_d = skid_full_q;
        err_cnt_d   = err_cnt_q;

        if (Flush) begin
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else begin
            case ({out_valid_q, skid_full_q})
                2'b00: begin
                    if (accept) begin
                        out_data_d  = entry_data;
                        out_sel_d   = In_Sel;
                        out_err_d   = entry_err;
                        out_valid_d = 1'b1;
                    end
                end
                2'b10: begin
                    if (accept && fire) begin
                        out_data_d = entry_data;
                        out_sel_d  = In_Sel;
                        out_err_d  = entry_err;
                    end else if (fire) begin
                        out_valid_d = 1'b0;
                    end else if (accept) begin
                        skid_data_d = entry_data;
                        skid_sel_d  = In_Sel;
                        skid_err_d  = entry_err;
                        skid_full_d = 1'b1;
                    end
                end
                default: begin
                    if (fire) begin
                        out_data_d  = skid_data_q;
                        out_sel_d   = skid_sel_q;
                        out_err_d   = skid_err_q;
                        skid_full_d = 1'b0;
                    end
                end
            endcase

            if (accept && entry_err && !(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            skid_err_q  <= 1'b0;
            skid_full_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            skid_err_q  <= skid_err_d;
            skid_full_q <= skid_full_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign In_Ready  = ~skid_full_q;
    assign Out_Data  = out_data_q;
    assign Out_Sel   = out_sel_q;
    assign Out_Err   = out_err_q;
    assign Out_Valid = out_valid_q;
    assign Err_Count = err_cnt_q;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: a 4-input instance driven through a scoreboard and vector
// table, and a 5-input instance for out-of-range selects and counter saturation.
module tb_mux_sel_pipe;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    // Instance A: WIDTH=4, NUM_IN=4
    logic        a_flush = 0, a_valid = 0, a_ordy = 0;
    logic [15:0] a_data = 16'h8421;
    logic [1:0]  a_sel = 0;
    logic        A_In_Ready, A_Out_Err, A_Out_Valid;
    logic [3:0]  A_Out_Data;
    logic [1:0]  A_Out_Sel;
    logic [7:0]  A_Err_Count;

    mux_sel_pipe #(.WIDTH(4), .NUM_IN(4), .ERR_CNT_W(8)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .Flush(a_flush),
        .In_Data(a_data), .In_Sel(a_sel), .In_Valid(a_valid), .In_Ready(A_In_Ready),
        .Out_Data(A_Out_Data), .Out_Sel(A_Out_Sel), .Out_Err(A_Out_Err),
        .Out_Valid(A_Out_Valid), .Out_Ready(a_ordy), .Err_Count(A_Err_Count)
    );

    // Instance B: WIDTH=4, NUM_IN=5 (3-bit select, codes 5..7 out of range)
    logic        b_flush = 0, b_valid = 0, b_ordy = 1;
    logic [19:0] b_data = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    logic [2:0]  b_sel = 0;
    logic        B_In_Ready, B_Out_Err, B_Out_Valid;
    logic [3:0]  B_Out_Data;
    logic [2:0]  B_Out_Sel;
    logic [7:0]  B_Err_Count;

    mux_sel_pipe #(.WIDTH(4), .NUM_IN(5), .ERR_CNT_W(8)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .Flush(b_flush),
        .In_Data(b_data), .In_Sel(b_sel), .In_Valid(b_valid), .In_Ready(B_In_Ready),
        .Out_Data(B_Out_Data), .Out_Sel(B_Out_Sel), .Out_Err(B_Out_Err),
        .Out_Valid(B_Out_Valid), .Out_Ready(b_ordy), .Err_Count(B_Err_Count)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [3:0] data;
        logic [1:0] sel;
        logic       err;
    } entry_t;

    entry_t sb[$];
    int     err_model = 0;
    int     fired = 0;
    logic   acc_last;

    // Check A against the scoreboard at the negedge, then apply the edge's effect to the model.
    task automatic sample();
        entry_t e;
        logic exp_valid, exp_ready;
        @(negedge Clk);
        exp_valid = (sb.size() > 0);
        exp_ready = (sb.size() < 2);
        chk("a_in_ready", int'(A_In_Ready), int'(exp_ready));
        chk("a_out_valid", int'(A_Out_Valid), int'(exp_valid));
        if (exp_valid) begin
            chk("a_out_data", int'(A_Out_Data), int'(sb[0].data));
            chk("a_out_sel", int'(A_Out_Sel), int'(sb[0].sel));
            chk("a_out_err", int'(A_Out_Err), int'(sb[0].err));
        end
        chk("a_err_count", int'(A_Err_Count), err_model);
        acc_last = a_valid && exp_ready && !a_flush;
        if (a_flush) begin
            sb.delete();
        end else begin
            if (exp_valid && a_ordy) begin
                void'(sb.pop_front());
                fired++;
            end
            if (acc_last) begin
                e.data = a_data[a_sel*4 +: 4];
                e.sel  = a_sel;
                e.err  = 1'b0;
                sb.push_back(e);
            end
        end
    endtask

    task automatic advance();
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] sel;
        logic       vld;
        logic       ordy;
        logic       ev;
        logic [3:0] ed;
        logic       er;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int sent;
        // inputs for the row, then outputs expected at that row's sample point
        vecs[0] = '{sel: 2'd3, vld: 1, ordy: 1, ev: 0, ed: 4'd0, er: 1};
        vecs[1] = '{sel: 2'd0, vld: 0, ordy: 0, ev: 1, ed: 4'd8, er: 1};
        vecs[2] = '{sel: 2'd0, vld: 0, ordy: 1, ev: 1, ed: 4'd8, er: 1};
        vecs[3] = '{sel: 2'd0, vld: 1, ordy: 0, ev: 0, ed: 4'd0, er: 1};
        vecs[4] = '{sel: 2'd1, vld: 1, ordy: 0, ev: 1, ed: 4'd1, er: 1};
        vecs[5] = '{sel: 2'd0, vld: 0, ordy: 0, ev: 1, ed: 4'd1, er: 0};
        vecs[6] = '{sel: 2'd2, vld: 1, ordy: 1, ev: 1, ed: 4'd1, er: 0};
        vecs[7] = '{sel: 2'd0, vld: 0, ordy: 1, ev: 1, ed: 4'd2, er: 1};
        vecs[8] = '{sel: 2'd0, vld: 0, ordy: 0, ev: 0, ed: 4'd0, er: 1};

        repeat (3) @(posedge Clk);
        #1;
        chk("rst_a_out_valid", int'(A_Out_Valid), 0);
        chk("rst_a_out_data", int'(A_Out_Data), 0);
        chk("rst_a_out_sel", int'(A_Out_Sel), 0);
        chk("rst_a_out_err", int'(A_Out_Err), 0);
        chk("rst_a_err_count", int'(A_Err_Count), 0);
        chk("rst_a_in_ready", int'(A_In_Ready), 1);
        chk("rst_b_out_valid", int'(B_Out_Valid), 0);
        chk("rst_b_in_ready", int'(B_In_Ready), 1);
        Reset_n = 1'b1;
        advance();

        // Instance B: out-of-range select, valid top channel, flush discard, saturation
        b_sel = 3'd7; b_valid = 1; advance(); b_valid = 0;
        chk("b_bad_valid", int'(B_Out_Valid), 1);
        chk("b_bad_err", int'(B_Out_Err), 1);
        chk("b_bad_data", int'(B_Out_Data), 0);
        chk("b_bad_sel", int'(B_Out_Sel), 7);
        chk("b_bad_count", int'(B_Err_Count), 1);
        b_sel = 3'd4; b_valid = 1; advance(); b_valid = 0;
        chk("b_ch4_err", int'(B_Out_Err), 0);
        chk("b_ch4_data", int'(B_Out_Data), 5);
        chk("b_ch4_count", int'(B_Err_Count), 1);
        b_sel = 3'd6; b_valid = 1; b_flush = 1; advance(); b_valid = 0; b_flush = 0;
        chk("b_flush_valid", int'(B_Out_Valid), 0);
        chk("b_flush_ready", int'(B_In_Ready), 1);
        chk("b_flush_count", int'(B_Err_Count), 1);
        b_valid = 1;
        for (int i = 0; i < 300; i++) begin
            b_sel = 3'($urandom_range(5, 7));
            advance();
        end
        b_valid = 0;
        chk("b_sat_count", int'(B_Err_Count), 255);

        // Instance A: vector table (single select, backpressure into the skid)
        a_data = 16'h8421;
        for (int i = 0; i < 9; i++) begin
            a_sel = vecs[i].sel; a_valid = vecs[i].vld; a_ordy = vecs[i].ordy;
            sample();
            chk($sformatf("vec%0d_out_valid", i), int'(A_Out_Valid), int'(vecs[i].ev));
            chk($sformatf("vec%0d_in_ready", i), int'(A_In_Ready), int'(vecs[i].er));
            if (vecs[i].ev) chk($sformatf("vec%0d_out_data", i), int'(A_Out_Data), int'(vecs[i].ed));
            advance();
        end

        // Flush while holding two entries, with a simultaneous input offered
        a_ordy = 0; a_valid = 1; a_sel = 2'd2; sample(); advance();
        a_sel = 2'd3; sample(); advance();
        chk("two_in_ready", int'(A_In_Ready), 0);
        a_flush = 1; a_sel = 2'd0; sample(); advance();
        a_flush = 0; a_valid = 0; a_ordy = 1;
        chk("flush_out_valid", int'(A_Out_Valid), 0);
        chk("flush_in_ready", int'(A_In_Ready), 1);
        repeat (3) begin sample(); advance(); end

        // Stream of 16 entries, selects cycling, random data and backpressure
        fired = 0; sent = 0;
        for (int cyc = 0; cyc < 200 && sent < 16; cyc++) begin
            a_valid = 1; a_sel = 2'(sent % 4); a_data = 16'($urandom);
            a_ordy = 1'($urandom_range(0, 1));
            sample();
            if (acc_last) sent++;
            advance();
        end
        a_valid = 0; a_ordy = 1;
        repeat (4) begin sample(); advance(); end
        chk("stream_sent", sent, 16);
        chk("stream_fired", fired, 16);
        chk("stream_drained", sb.size(), 0);

        // Async reset pulse while holding two entries
        a_ordy = 0; a_valid = 1; a_sel = 2'd1; sample(); advance();
        a_sel = 2'd2; sample(); advance();
        a_valid = 0;
        chk("pre_rst_in_ready", int'(A_In_Ready), 0);
        #1 Reset_n = 1'b0;
        #1;
        chk("async_rst_out_valid", int'(A_Out_Valid), 0);
        chk("async_rst_in_ready", int'(A_In_Ready), 1);
        sb.delete(); err_model = 0;
        #1 Reset_n = 1'b1;
        a_ordy = 1;
        repeat (3) begin sample(); advance(); end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
